// File: rtl/psum_accumulator.sv
// psum_accumulator: per-lane saturating partial-sum accumulator with round/shift/clamp requantisation.
// Optional feature macro: PSUM_ACC_RELU_EN (unsigned ReLU output); default build gives signed clamped output.
module psum_accumulator #(
    parameter int PSUM_W = 18,
    parameter int ACC_W  = 24,
    parameter int LANES  = 64,
    parameter int OUT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [LANES*PSUM_W-1:0] psum_in,
    input  logic                    last_tile,
    input  logic [4:0]              shift,
    output logic                    act_valid,
    input  logic                    act_ready,
    output logic [LANES*OUT_W-1:0]  act_out,
    output logic                    sat_flag
);

    typedef enum logic [1:0] {ACCUM, QUANT, OUTPUT} state_t;

    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
`ifdef PSUM_ACC_RELU_EN
    localparam int Q_HI_I = (1 << OUT_W) - 1;
    localparam int Q_LO_I = 0;
`else
    localparam int Q_HI_I = (1 << (OUT_W - 1)) - 1;
    localparam int Q_LO_I = -(1 << (OUT_W - 1));
`endif
    localparam logic signed [ACC_W:0] Q_HI = (ACC_W+1)'(Q_HI_I);
    localparam logic signed [ACC_W:0] Q_LO = (ACC_W+1)'(Q_LO_I);

    state_t                  state, state_nxt;
    logic                    empty;
    logic                    accept;
    logic [4:0]              shift_q;
    logic [4:0]              shift_lim;
    logic signed [ACC_W-1:0] acc     [LANES];
    logic signed [ACC_W-1:0] acc_nxt [LANES];
    logic [LANES-1:0]        lane_sat;
    logic signed [ACC_W:0]   lane_ext, base, sum;
    logic signed [ACC_W:0]   rnd, r, q;
    logic [LANES*OUT_W-1:0]  act_q;

    always_comb begin
        state_nxt  = state;
        psum_ready = 1'b0;
        act_valid  = 1'b0;
        case (state)
            ACCUM: begin
                psum_ready = 1'b1;
                if (psum_valid && last_tile) state_nxt = QUANT;
            end
            QUANT:  state_nxt = OUTPUT;
            OUTPUT: begin
                act_valid = 1'b1;
                if (act_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign accept    = psum_valid && psum_ready;
    assign shift_lim = (int'(shift) >= ACC_W) ? 5'(ACC_W - 1) : shift;

    // Work one bit wider than the accumulator so overflow shows up as an out-of-range sum.
    always_comb begin
        lane_sat = '0;
        lane_ext = '0;
        base     = '0;
        sum      = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_ext = (ACC_W+1)'($signed(psum_in[PSUM_W*i +: PSUM_W]));
            base     = empty ? '0 : (ACC_W+1)'(acc[i]);
            sum      = base + lane_ext;
            if (sum > ACC_MAX) begin
                acc_nxt[i]  = ACC_MAX[ACC_W-1:0];
                lane_sat[i] = 1'b1;
            end else if (sum < ACC_MIN) begin
                acc_nxt[i]  = ACC_MIN[ACC_W-1:0];
                lane_sat[i] = 1'b1;
            end else begin
                acc_nxt[i]  = sum[ACC_W-1:0];
            end
        end
    end

    // ReLU falls out of the clamp: the unsigned range has a lower bound of zero.
    always_comb begin
        act_q = '0;
        r     = '0;
        q     = '0;
        rnd   = (shift_q != 5'd0) ? ((ACC_W+1)'(1) << (shift_q - 5'd1)) : '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r = (ACC_W+1)'(acc[i]) + rnd;
            q = r >>> shift_q;
            if (q > Q_HI)      act_q[OUT_W*i +: OUT_W] = Q_HI[OUT_W-1:0];
            else if (q < Q_LO) act_q[OUT_W*i +: OUT_W] = Q_LO[OUT_W-1:0];
            else               act_q[OUT_W*i +: OUT_W] = q[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            empty    <= 1'b1;
            shift_q  <= '0;
            act_out  <= '0;
            sat_flag <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
                empty    <= 1'b0;
                sat_flag <= empty ? (|lane_sat) : (sat_flag | (|lane_sat));
                if (last_tile) shift_q <= shift_lim;
            end
            if (state == QUANT) act_out <= act_q;
            if (state == OUTPUT && act_ready) empty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: randomized and directed checks of psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;

    localparam int PSUM_W = 18;
    localparam int ACC_W  = 24;
    localparam int LANES  = 64;
    localparam int OUT_W  = 4;
    localparam longint ACC_MAXM = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MINM = -(longint'(1) << (ACC_W - 1));
`ifdef PSUM_ACC_RELU_EN
    localparam int OUT_LO = 0;
    localparam int OUT_HI = 15;
    localparam logic [3:0] E_SINGLE = 4'd13, E_TWO = 4'd9, E_THIRD = 4'd9, E_NEG20 = 4'd0,
                           E_NEG1000 = 4'd0, E_SAT = 4'd8, E_RST = 4'd15;
`else
    localparam int OUT_LO = -8;
    localparam int OUT_HI = 7;
    localparam logic [3:0] E_SINGLE = 4'd7, E_TWO = 4'd7, E_THIRD = 4'd7, E_NEG20 = 4'hB,
                           E_NEG1000 = 4'h8, E_SAT = 4'd7, E_RST = 4'd7;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    psum_valid;
    logic                    psum_ready;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic                    last_tile;
    logic [4:0]              shift;
    logic                    act_valid;
    logic                    act_ready;
    logic [LANES*OUT_W-1:0]  act_out;
    logic                    sat_flag;

    psum_accumulator #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .LANES(LANES), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_in(psum_in), .last_tile(last_tile), .shift(shift), .act_valid(act_valid),
        .act_ready(act_ready), .act_out(act_out), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint acc_m [LANES];
    bit     empty_m;
    bit     sat_m;
    int     shift_m;
    int     vals [LANES];
    int     vectors;
    int     miscompares;

    function automatic logic [LANES*OUT_W-1:0] model_act();
        logic [LANES*OUT_W-1:0] res;
        longint d, r, q;
        res = '0;
        d = longint'(1) << shift_m;
        for (int i = 0; i < LANES; i++) begin
            r = acc_m[i] + ((shift_m > 0) ? d / 2 : 0);
            q = r / d;
            if (r < 0 && (r % d) != 0) q = q - 1;
            if (q > OUT_HI) q = OUT_HI;
            if (q < OUT_LO) q = OUT_LO;
            res[OUT_W*i +: OUT_W] = q[OUT_W-1:0];
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) acc_m[i] = 0;
        empty_m = 1'b1;
        sat_m   = 1'b0;
        shift_m = 0;
    endtask

    task automatic clear_vals();
        for (int i = 0; i < LANES; i++) vals[i] = 0;
    endtask

    task automatic load_bus(input bit last, input int sh);
        for (int i = 0; i < LANES; i++) psum_in[PSUM_W*i +: PSUM_W] = vals[i][PSUM_W-1:0];
        last_tile = last;
        shift     = sh[4:0];
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        psum_valid = 1'b0;
        act_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drive_beat(input bit last, input int sh);
        bit accepted;
        bit any_sat;
        longint s;
        load_bus(last, sh);
        psum_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            if (psum_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        psum_valid = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL beat_accept: psum_ready=%b after 50 cycles, required 1", psum_ready);
        end else begin
            any_sat = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s = (empty_m ? 0 : acc_m[i]) + longint'(vals[i]);
                if (s > ACC_MAXM) begin s = ACC_MAXM; any_sat = 1'b1; end
                if (s < ACC_MINM) begin s = ACC_MINM; any_sat = 1'b1; end
                acc_m[i] = s;
            end
            sat_m   = empty_m ? any_sat : (sat_m | any_sat);
            empty_m = 1'b0;
            if (last) shift_m = (sh >= ACC_W) ? ACC_W - 1 : sh;
        end
    endtask

    // Called #1 after the edge that accepted a last_tile beat; hold = cycles of act_ready=0 in OUTPUT.
    task automatic finish_group(input int hold);
        logic [LANES*OUT_W-1:0] exp_act, snap;
        exp_act   = model_act();
        act_ready = (hold == 0);
        vectors++;
        if (act_valid !== 1'b0 || psum_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL quant_phase: act_valid=%b psum_ready=%b, required 0 0", act_valid, psum_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (act_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: act_valid=%b two edges after last beat, required 1", act_valid);
        end
        vectors++;
        if (act_out !== exp_act) begin
            miscompares++;
            $display("FAIL act_out: got %h required %h", act_out, exp_act);
        end
        vectors++;
        if (sat_flag !== sat_m) begin
            miscompares++;
            $display("FAIL sat_flag: got %b required %b", sat_flag, sat_m);
        end
        snap = act_out;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (act_valid !== 1'b1 || psum_ready !== 1'b0 || act_out !== snap) begin
                miscompares++;
                $display("FAIL hold_stable: act_valid=%b psum_ready=%b act_out=%h, required 1 0 %h",
                         act_valid, psum_ready, act_out, snap);
            end
        end
        act_ready = 1'b1;
        @(posedge clk);
        #1;
        act_ready = 1'b0;
        vectors++;
        if (act_valid !== 1'b0 || psum_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release: act_valid=%b psum_ready=%b, required 0 1", act_valid, psum_ready);
        end
        empty_m = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (psum_ready !== 1'b1 || act_valid !== 1'b0 || act_out !== '0 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b valid=%b act_out=%h sat=%b, required 1 0 0 0",
                     psum_ready, act_valid, act_out, sat_flag);
        end
    endtask

    task automatic test_single_tile();
        clear_vals();
        vals[0] = 100;
        drive_beat(1'b1, 3);
        finish_group(0);
        vectors++;
        if (act_out[3:0] !== E_SINGLE || act_out[LANES*OUT_W-1:4] !== '0) begin
            miscompares++;
            $display("FAIL single_tile: lane0=%h rest=%h, required %h and 0", act_out[3:0],
                     act_out[LANES*OUT_W-1:4], E_SINGLE);
        end
    endtask

    task automatic test_two_tiles();
        clear_vals();
        vals[5] = 100;
        drive_beat(1'b0, 0);
        vals[5] = 50;
        drive_beat(1'b1, 4);
        finish_group(1);
        vectors++;
        if (act_out[23:20] !== E_TWO) begin
            miscompares++;
            $display("FAIL two_tiles: lane5=%h required %h", act_out[23:20], E_TWO);
        end
        vals[5] = 300;
        drive_beat(1'b1, 5);
        finish_group(0);
        vectors++;
        if (act_out[23:20] !== E_THIRD) begin
            miscompares++;
            $display("FAIL fresh_group: lane5=%h required %h", act_out[23:20], E_THIRD);
        end
    endtask

    task automatic test_negative();
        clear_vals();
        vals[0] = -20;
        drive_beat(1'b1, 2);
        finish_group(2);
        vectors++;
        if (act_out[3:0] !== E_NEG20) begin
            miscompares++;
            $display("FAIL negative_round: lane0=%h required %h", act_out[3:0], E_NEG20);
        end
        vals[0] = -1000;
        drive_beat(1'b1, 0);
        finish_group(0);
        vectors++;
        if (act_out[3:0] !== E_NEG1000) begin
            miscompares++;
            $display("FAIL negative_clamp: lane0=%h required %h", act_out[3:0], E_NEG1000);
        end
    endtask

    task automatic test_saturation();
        clear_vals();
        vals[3] = 131071;
        for (int b = 0; b < 64; b++) drive_beat(1'b0, 0);
        drive_beat(1'b1, 20);
        finish_group(0);
        vectors++;
        if (act_out[15:12] !== E_SAT || sat_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation: lane3=%h sat_flag=%b, required %h 1", act_out[15:12], sat_flag, E_SAT);
        end
        vals[3] = 5;
        drive_beat(1'b1, 1);
        vectors++;
        if (sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear: sat_flag=%b required 0", sat_flag);
        end
        finish_group(0);
    endtask

    task automatic test_backpressure();
        clear_vals();
        vals[7] = 40;
        drive_beat(1'b1, 2);
        vals[7] = 24;
        load_bus(1'b1, 1);
        psum_valid = 1'b1;
        finish_group(5);
        drive_beat(1'b1, 1);
        finish_group(0);
        vectors++;
`ifdef PSUM_ACC_RELU_EN
        if (act_out[31:28] !== 4'd12) begin
`else
        if (act_out[31:28] !== 4'd7) begin
`endif
            miscompares++;
            $display("FAIL held_beat: lane7=%h, held beat consumed wrongly", act_out[31:28]);
        end
    endtask

    task automatic test_reset_mid_group();
        clear_vals();
        for (int b = 0; b < 3; b++) begin
            vals[0] = int'($urandom_range(0, 1000));
            vals[9] = int'($urandom_range(0, 131071));
            drive_beat(1'b0, 0);
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if (psum_ready !== 1'b1 || act_valid !== 1'b0 || act_out !== '0 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: ready=%b valid=%b act_out=%h sat=%b, required 1 0 0 0",
                     psum_ready, act_valid, act_out, sat_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_vals();
        vals[0] = 64;
        drive_beat(1'b1, 2);
        finish_group(0);
        vectors++;
        if (act_out[3:0] !== E_RST || act_out[39:36] !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset: lane0=%h lane9=%h, required %h 0", act_out[3:0], act_out[39:36], E_RST);
        end
    endtask

    task automatic test_random();
        int tiles;
        for (int g = 0; g < 25; g++) begin
            tiles = int'($urandom_range(1, 4));
            for (int t = 0; t < tiles; t++) begin
                for (int i = 0; i < LANES; i++) begin
                    if ($urandom_range(0, 1) == 0) vals[i] = int'($urandom_range(0, 4000)) - 2000;
                    else                           vals[i] = int'($urandom_range(0, 262143)) - 131072;
                end
                drive_beat(t == tiles - 1, int'($urandom_range(0, 31)));
            end
            finish_group(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        psum_valid  = 1'b0;
        psum_in     = '0;
        last_tile   = 1'b0;
        shift       = '0;
        act_ready   = 1'b0;
        clear_vals();
        model_reset();
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
